slice_sequencer: RTL and testbench

SLICE_SEQUENCER -- requirements
Module: slice_sequencer

---
 rtl/slice_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_slice_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_sequencer.sv
// Slice sequencer: measures stock length ultrasonically, divides it into equal
// segments and steps the carriage through cut/return cycles.
module slice_sequencer #(
  parameter int DIST_W       = 32,
  parameter int CNT_W        = 5,
  parameter int TRIG_HOLD    = 500,
  parameter int ECHO_TIMEOUT = 2000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [CNT_W-1:0]  slice_num,
  input  logic              valid,
  input  logic [DIST_W-1:0] distance,
  input  logic              cut_end,
  output logic              trigger,
  output logic              move,
  output logic              back,
  output logic              cut,
  output logic              busy,
  output logic              finish,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, INIT_TRIG, INIT_WAIT, DIVIDE, TRIG, WAIT, CUT, BACK_TRIG, BACK_WAIT, PAUSE
  } state_t;

  localparam int HOLD_W  = $clog2(TRIG_HOLD + 1);
  localparam int TO_W    = $clog2(ECHO_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int DIVC_W  = $clog2(DIST_W + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(TRIG_HOLD - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ECHO_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [DIVC_W-1:0]  DIV_LAST   = DIVC_W'(DIST_W - 1);

  state_t              state, saved_state;
  logic [CNT_W-1:0]    slices, cut_cnt;
  logic [DIST_W-1:0]   length, segment, location, quot;
  logic [DIST_W:0]     rem;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TO_W-1:0]     wait_cnt;
  logic [RETRY_W-1:0]  retry;
  logic [DIVC_W-1:0]   div_cnt;

  logic [DIST_W:0]     rem_shift, rem_diff;
  logic [DIST_W-1:0]   quot_next;
  logic                cut_hit;

  function automatic state_t trig_of(input state_t s);
    case (s)
      INIT_TRIG, INIT_WAIT: trig_of = INIT_TRIG;
      BACK_TRIG, BACK_WAIT: trig_of = BACK_TRIG;
      default:              trig_of = TRIG;
    endcase
  endfunction

  function automatic state_t wait_of(input state_t s);
    case (s)
      INIT_TRIG: wait_of = INIT_WAIT;
      BACK_TRIG: wait_of = BACK_WAIT;
      default:   wait_of = WAIT;
    endcase
  endfunction

  // One restoring-division step per DIVIDE cycle; a negative trial difference
  // shows up as the top bit because the partial remainder never exceeds 2*slices.
  always_comb begin
    rem_shift = {rem[DIST_W-1:0], quot[DIST_W-1]};
    rem_diff  = rem_shift - {{(DIST_W + 1 - CNT_W){1'b0}}, slices};
    quot_next = {quot[DIST_W-2:0], ~rem_diff[DIST_W]};
  end

  // A segment larger than the remaining location always counts as a cut.
  assign cut_hit = (segment > location) || (distance <= location - segment);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      saved_state <= IDLE;
      slices      <= '0;
      cut_cnt     <= '0;
      length      <= '0;
      segment     <= '0;
      location    <= '0;
      quot        <= '0;
      rem         <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      retry       <= '0;
      div_cnt     <= '0;
      trigger     <= 1'b0;
      move        <= 1'b0;
      back        <= 1'b0;
      cut         <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      err         <= 1'b0;
    end else begin
      finish <= 1'b0;
      err    <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        trigger <= 1'b0;
        move    <= 1'b0;
        back    <= 1'b0;
        cut     <= 1'b0;
        busy    <= 1'b0;
      end else if (pause && state != IDLE) begin
        if (state == PAUSE) begin
          case (saved_state)
            CUT: begin
              state <= CUT;
              cut   <= 1'b1;
            end
            DIVIDE: state <= DIVIDE;
            default: begin
              state    <= trig_of(saved_state);
              hold_cnt <= '0;
              trigger  <= 1'b1;
              move     <= (trig_of(saved_state) != INIT_TRIG);
              back     <= (trig_of(saved_state) == BACK_TRIG);
            end
          endcase
        end else begin
          saved_state <= state;
          state       <= PAUSE;
          trigger     <= 1'b0;
          move        <= 1'b0;
          back        <= 1'b0;
          cut         <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (start) begin
            slices   <= slice_num;
            cut_cnt  <= '0;
            retry    <= '0;
            hold_cnt <= '0;
            trigger  <= 1'b1;
            busy     <= 1'b1;
            state    <= INIT_TRIG;
          end
          INIT_TRIG, TRIG, BACK_TRIG: begin
            if (hold_cnt == HOLD_LAST) begin
              trigger  <= 1'b0;
              wait_cnt <= '0;
              state    <= wait_of(state);
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          INIT_WAIT, WAIT, BACK_WAIT: begin
            if (valid) begin
              retry <= '0;
              case (state)
                INIT_WAIT: begin
                  length   <= distance;
                  location <= distance;
                  if (slices <= CNT_W'(1)) begin
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                  end else begin
                    quot    <= distance;
                    rem     <= '0;
                    div_cnt <= '0;
                    state   <= DIVIDE;
                  end
                end
                WAIT: begin
                  if (cut_hit) begin
                    move  <= 1'b0;
                    cut   <= 1'b1;
                    state <= CUT;
                  end else begin
                    hold_cnt <= '0;
                    trigger  <= 1'b1;
                    state    <= TRIG;
                  end
                end
                default: begin
                  if (distance >= length) begin
                    move   <= 1'b0;
                    back   <= 1'b0;
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                  end else begin
                    hold_cnt <= '0;
                    trigger  <= 1'b1;
                    state    <= BACK_TRIG;
                  end
                end
              endcase
            end else if (wait_cnt == TO_LAST) begin
              if (retry == RETRY_LAST) begin
                retry <= '0;
                move  <= 1'b0;
                back  <= 1'b0;
                cut   <= 1'b0;
                busy  <= 1'b0;
                err   <= 1'b1;
                state <= IDLE;
              end else begin
                retry    <= retry + 1'b1;
                hold_cnt <= '0;
                trigger  <= 1'b1;
                state    <= trig_of(state);
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          DIVIDE: begin
            rem     <= rem_diff[DIST_W] ? rem_shift : rem_diff;
            quot    <= quot_next;
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) begin
              segment  <= quot_next;
              hold_cnt <= '0;
              trigger  <= 1'b1;
              move     <= 1'b1;
              state    <= TRIG;
            end
          end
          CUT: if (cut_end) begin
            cut      <= 1'b0;
            location <= location - segment;
            cut_cnt  <= cut_cnt + 1'b1;
            hold_cnt <= '0;
            trigger  <= 1'b1;
            move     <= 1'b1;
            if (cut_cnt + 1'b1 == slices - 1'b1) begin
              back  <= 1'b1;
              state <= BACK_TRIG;
            end else begin
              state <= TRIG;
            end
          end
          PAUSE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slice_sequencer.sv
// Bench for slice_sequencer: a job-level reference model predicts every output
// each cycle while directed scenarios and random jobs drive the inputs.
module tb_slice_sequencer;

  localparam int DW = 16;
  localparam int CW = 5;
  localparam int TH = 4;
  localparam int ET = 10;
  localparam int MR = 3;
  localparam longint MASK = (64'd1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, pause, abort, valid, cut_end;
  logic [CW-1:0] slice_num;
  logic [DW-1:0] distance;
  logic          trigger, move, back, cut, busy, finish, err;

  int checks = 0;
  int errors = 0;

  slice_sequencer #(
    .DIST_W(DW), .CNT_W(CW), .TRIG_HOLD(TH), .ECHO_TIMEOUT(ET), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .slice_num(slice_num), .valid(valid), .distance(distance), .cut_end(cut_end),
    .trigger(trigger), .move(move), .back(back), .cut(cut), .busy(busy),
    .finish(finish), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: job phases, a countdown for the trigger pulse, integer division.
  localparam int MD_IDLE = 0, MD_INIT = 1, MD_DIV = 2, MD_FWD = 3, MD_CUT = 4,
                 MD_BACK = 5, MD_PAUSED = 6;
  int     mMode = 0, mSaved = 0, trigLeft = 0, waitCnt = 0, retries = 0;
  int     divLeft = 0, cutsM = 0, slicesM = 0;
  longint lengthM = 0, locationM = 0, segmentM = 0;
  bit     eTrig, eMove, eBack, eCut, eBusy, eFinish, eErr;

  task automatic mBeginMeasure(input int m);
    mMode = m; trigLeft = TH; waitCnt = 0;
    eTrig = 1; eMove = (m != MD_INIT); eBack = (m == MD_BACK); eCut = 0;
  endtask

  task automatic mToIdle();
    mMode = MD_IDLE; eTrig = 0; eMove = 0; eBack = 0; eCut = 0;
  endtask

  task automatic mEcho(input longint d);
    retries = 0;
    case (mMode)
      MD_INIT: begin
        lengthM = d; locationM = d;
        if (slicesM <= 1) begin mToIdle(); eFinish = 1; end
        else begin mMode = MD_DIV; divLeft = DW; end
      end
      MD_FWD:
        if (segmentM > locationM || d <= locationM - segmentM) begin
          mMode = MD_CUT; eMove = 0; eCut = 1;
        end else mBeginMeasure(MD_FWD);
      default:
        if (d >= lengthM) begin mToIdle(); eFinish = 1; end
        else mBeginMeasure(MD_BACK);
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mToIdle(); mSaved = 0; trigLeft = 0; waitCnt = 0; retries = 0; divLeft = 0;
      cutsM = 0; slicesM = 0; lengthM = 0; locationM = 0; segmentM = 0;
      eBusy = 0; eFinish = 0; eErr = 0;
    end else begin
      eFinish = 0; eErr = 0;
      if (abort) mToIdle();
      else if (pause && mMode != MD_IDLE) begin
        if (mMode == MD_PAUSED) begin
          if (mSaved == MD_CUT) begin mMode = MD_CUT; eCut = 1; end
          else if (mSaved == MD_DIV) mMode = MD_DIV;
          else mBeginMeasure(mSaved);
        end else begin
          mSaved = mMode; mMode = MD_PAUSED;
          eTrig = 0; eMove = 0; eBack = 0; eCut = 0;
        end
      end else begin
        case (mMode)
          MD_IDLE: if (start) begin
            slicesM = int'(slice_num); cutsM = 0; retries = 0; mBeginMeasure(MD_INIT);
          end
          MD_INIT, MD_FWD, MD_BACK:
            if (trigLeft > 0) begin
              trigLeft--;
              if (trigLeft == 0) eTrig = 0;
            end else if (valid) mEcho(longint'(distance));
            else begin
              waitCnt++;
              if (waitCnt == ET) begin
                retries++;
                if (retries == MR) begin mToIdle(); eErr = 1; end
                else mBeginMeasure(mMode);
              end
            end
          MD_DIV: begin
            divLeft--;
            if (divLeft == 0) begin
              segmentM = lengthM / slicesM;
              mBeginMeasure(MD_FWD);
            end
          end
          MD_CUT: if (cut_end) begin
            locationM = (locationM - segmentM) & MASK;
            cutsM++;
            if (cutsM == slicesM - 1) mBeginMeasure(MD_BACK);
            else mBeginMeasure(MD_FWD);
          end
          default: ;
        endcase
      end
      eBusy = (mMode != MD_IDLE);
    end
  end

  function automatic logic [6:0] outs();
    return {trigger, move, back, cut, busy, finish, err};
  endfunction

  always @(posedge clk) begin
    #2;
    checks++;
    if (outs() !== {eTrig, eMove, eBack, eCut, eBusy, eFinish, eErr}) begin
      errors++;
      $display("[TB] FAIL cycle_outputs t=%0t: trig/move/back/cut/busy/finish/err got %b required %b",
               $time, outs(), {eTrig, eMove, eBack, eCut, eBusy, eFinish, eErr});
    end
  end

  int  cutRises = 0, finishCnt = 0, errCnt = 0, trigHighs = 0;
  bit  moveSeen = 0, cutSeen = 0, cutPrev = 0;

  always @(posedge clk) begin
    #3;
    if (cut && !cutPrev) cutRises++;
    if (move) moveSeen = 1;
    if (cut) cutSeen = 1;
    if (finish) finishCnt++;
    if (err) errCnt++;
    if (trigger) trigHighs++;
    cutPrev = cut;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  function automatic bit inWindow();
    return (mMode == MD_INIT || mMode == MD_FWD || mMode == MD_BACK) && trigLeft == 0;
  endfunction

  task automatic waitWindow(input string tag);
    int n = 0;
    while (!inWindow() && n < 500) begin @(negedge clk); n++; end
    if (!inWindow()) begin
      checks++; errors++;
      $display("[TB] FAIL %s: echo window not reached, got mode %0d required a wait phase", tag, mMode);
    end
  endtask

  task automatic sendEcho(input string tag, input int d);
    waitWindow(tag);
    valid = 1; distance = DW'(d);
    @(negedge clk);
    valid = 0;
  endtask

  task automatic doCut(input string tag);
    int n = 0;
    while (mMode != MD_CUT && n < 500) begin @(negedge clk); n++; end
    if (mMode != MD_CUT) begin
      checks++; errors++;
      $display("[TB] FAIL %s: cut phase not reached, got mode %0d required %0d", tag, mMode, MD_CUT);
    end
    repeat (2) @(negedge clk);
    cut_end = 1;
    @(negedge clk);
    cut_end = 0;
  endtask

  task automatic pulseStart(input int n);
    slice_num = CW'(n); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulsePause();
    pause = 1; @(negedge clk); pause = 0;
  endtask

  task automatic pulseAbort();
    abort = 1; @(negedge clk); abort = 0;
  endtask

  function automatic logic [DW-1:0] pickDistance();
    longint thr;
    case (mMode)
      MD_INIT: return DW'($urandom_range(50, 4000));
      MD_FWD: begin
        if (segmentM > locationM) return DW'($urandom_range(0, 5000));
        thr = locationM - segmentM;
        if ($urandom_range(0, 99) < 55) return DW'(thr);
        return DW'(thr + 1 + $urandom_range(0, 30));
      end
      default: begin
        if ($urandom_range(0, 99) < 50) return DW'(lengthM + $urandom_range(0, 9));
        return DW'(lengthM / 2);
      end
    endcase
  endfunction

  // One random job: echoes, cut handshakes, spurious valids/starts, pauses and rare aborts.
  task automatic applyStimulus();
    int guard = 0;
    int r;
    pulseStart($urandom_range(0, 6));
    while (mMode != MD_IDLE && guard < 3000) begin
      guard++;
      r = $urandom_range(0, 99);
      start = (r >= 97);
      if (r == 0) abort = 1;
      else if (r < 4) pause = 1;
      else if (mMode == MD_PAUSED) pause = (r < 30);
      else if (inWindow()) begin
        if (r < 75) begin valid = 1; distance = pickDistance(); end
      end
      else if (mMode == MD_CUT) cut_end = (r < 50);
      else if (r < 15) begin valid = 1; distance = DW'($urandom); end
      slice_num = CW'($urandom_range(0, 31));
      @(negedge clk);
      valid = 0; abort = 0; pause = 0; cut_end = 0; start = 0;
    end
    if (mMode != MD_IDLE) begin
      checks++; errors++;
      $display("[TB] FAIL random_job: job did not end, got mode %0d required %0d", mMode, MD_IDLE);
      pulseAbort();
    end
  endtask

  int expThr[4] = '{803, 603, 403, 203};

  initial begin
    int n;
    rst = 1; start = 0; pause = 0; abort = 0; valid = 0; cut_end = 0;
    slice_num = '0; distance = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", outs(), 0);
    rst = 0;

    // Three slices from 300: cuts at 200 and 100, return finishes at 300.
    pulseStart(3);
    cutRises = 0;
    sendEcho("req29_init", 300);
    sendEcho("req29_fwd", 250);
    checkOutput("req29_segment_model", segmentM, 100);
    sendEcho("req29_fwd", 200);
    doCut("req29_cut1");
    sendEcho("req29_fwd", 150);
    sendEcho("req29_fwd", 100);
    doCut("req29_cut2");
    checkOutput("req29_cut_rises", cutRises, 2);
    checkOutput("req29_back_after_cut2", back, 1);
    sendEcho("req29_back", 200);
    sendEcho("req29_back", 300);
    checkOutput("req29_finish_pulse", finish, 1);
    @(negedge clk);
    checkOutput("req29_finish_width", finish, 0);
    checkOutput("req29_idle_busy", busy, 0);

    // Five slices of 1003: divider latency and the four cut thresholds.
    pulseStart(5);
    sendEcho("req30_init", 1003);
    n = 0;
    while (!trigger && n < 100) begin @(negedge clk); n++; end
    checkOutput("req30_divide_cycles", n, DW);
    checkOutput("req30_segment_model", segmentM, 200);
    for (int k = 0; k < 4; k++) begin
      waitWindow("req30_window");
      checkOutput("req30_threshold", locationM - segmentM, expThr[k]);
      sendEcho("req30_nocut", int'(locationM - segmentM + 1));
      sendEcho("req30_cut", int'(locationM - segmentM));
      doCut("req30_cut");
    end
    sendEcho("req30_back", 1003);
    checkOutput("req30_finish_pulse", finish, 1);

    // Single slice: finish without any motion or cut.
    moveSeen = 0; cutSeen = 0;
    pulseStart(1);
    sendEcho("req31_init", 500);
    checkOutput("req31_finish_pulse", finish, 1);
    checkOutput("req31_busy", busy, 0);
    checkOutput("req31_move_seen", moveSeen, 0);
    checkOutput("req31_cut_seen", cutSeen, 0);

    // Silent sensor: three 4-cycle triggers, then err.
    trigHighs = 0; errCnt = 0;
    pulseStart(3);
    repeat (60) @(negedge clk);
    checkOutput("req32_trigger_cycles", trigHighs, 3 * TH);
    checkOutput("req32_err_pulses", errCnt, 1);
    checkOutput("req32_busy", busy, 0);

    // Pause during trigger hold, then during a cut.
    pulseStart(3);
    sendEcho("req33_init", 300);
    n = 0;
    while (!(mMode == MD_FWD && trigLeft == TH - 1) && n < 200) begin @(negedge clk); n++; end
    checkOutput("req33_reach_hold2", trigLeft, TH - 1);
    pulsePause();
    checkOutput("req33_paused_trigger", trigger, 0);
    checkOutput("req33_paused_move", move, 0);
    checkOutput("req33_paused_busy", busy, 1);
    repeat (50) @(negedge clk);
    pulsePause();
    n = 0;
    while (trigger && n < 50) begin n++; @(negedge clk); end
    checkOutput("req33_resume_hold", n, TH);
    sendEcho("req33_fwd", 200);
    checkOutput("req33_cut_high", cut, 1);
    pulsePause();
    checkOutput("req33_cut_paused", cut, 0);
    repeat (5) @(negedge clk);
    pulsePause();
    checkOutput("req33_cut_resumed", cut, 1);
    pulseAbort();
    checkOutput("req33_abort_busy", busy, 0);

    // Abort beats pause in WAIT; reset mid-cut clears outputs at once.
    finishCnt = 0;
    pulseStart(3);
    sendEcho("req34_init", 300);
    waitWindow("req34_wait");
    abort = 1; pause = 1;
    @(negedge clk);
    abort = 0; pause = 0;
    checkOutput("req34_abort_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    checkOutput("req34_no_finish", finishCnt, 0);
    pulseStart(3);
    sendEcho("req34_init2", 300);
    sendEcho("req34_fwd", 200);
    checkOutput("req34_cut_before_rst", cut, 1);
    rst = 1;
    #1;
    checkOutput("req34_rst_outputs", outs(), 0);
    @(negedge clk);
    rst = 0;
    pulseStart(3);
    checkOutput("req34_start_after_rst", trigger, 1);
    pulseAbort();

    for (int j = 0; j < 30; j++) applyStimulus();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
